some_sub_module: RTL and testbench

//  Saturating nibble accumulator and event counter in the pipe_pal datapath.

---
 rtl/some_sub_module.sv | 158 +++++++++++++++
 tb/tb_some_sub_module.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/some_sub_module.sv
// -----------------------------------------------------------------------------
// some_sub_module
//
// Saturating nibble accumulator and accepted-strobe counter for the pipe_pal
// datapath. On every rising edge where the strobe `a` is high, the 4-bit
// operand `c` is added to (b=0) or subtracted from (b=1) an unsigned
// accumulator. The result is clamped to [0, 2^W_ACC-1] and never wraps.
// Registered status outputs report fill, saturation and threshold state to the
// parent block.
//
// Parameters
//   W_ACC   accumulator width in bits (must be >= 5 and < 31)
//   W_CNT   accepted-strobe counter width in bits (>= 1)
//   THRESH  o_hit threshold, compared unsigned against the accumulator
//
// Ports
//   a        in   1      sample strobe; operand accepted on any edge with a=1
//   b        in   1      operation select: 0 = add, 1 = subtract
//   c        in   4      unsigned operand nibble
//   i_clk    in   1      clock, rising edge
//   resetn   in   1      asynchronous active-low reset
//   o_acc    out  W_ACC  accumulator value
//   o_cnt    out  W_CNT  accepted strobes, modulo 2^W_CNT
//   o_last   out  4      last accepted operand
//   o_valid  out  1      one-cycle pulse in the cycle after an accepted strobe
//   o_sat    out  1      one-cycle pulse: the last accepted operation clamped
//   o_hit    out  1      level: o_acc >= THRESH (forced low while in reset)
//
// The port list starts with a, b, c because the parent connects `a`
// positionally.
// -----------------------------------------------------------------------------
module some_sub_module #(
  parameter int unsigned W_ACC  = 8,
  parameter int unsigned W_CNT  = 8,
  parameter int unsigned THRESH = 128
) (
  input  logic             a,
  input  logic             b,
  input  logic [3:0]       c,
  input  logic             i_clk,
  input  logic             resetn,
  output logic [W_ACC-1:0] o_acc,
  output logic [W_CNT-1:0] o_cnt,
  output logic [3:0]       o_last,
  output logic             o_valid,
  output logic             o_sat,
  output logic             o_hit
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [W_ACC-1:0] ACC_MAX = {W_ACC{1'b1}};

  // The threshold is compared in W_ACC+1 bits so that THRESH = 2^W_ACC
  // (one past the maximum accumulator value) is representable and simply
  // never hits. Anything at or above 2^(W_ACC+1) would be truncated by that
  // cast, so it is flagged separately and also never hits.
  localparam logic [W_ACC:0] THRESH_EXT         = (W_ACC + 1)'(THRESH);
  localparam bit             THRESH_UNREACHABLE = (THRESH >> (W_ACC + 1)) != 0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W_ACC-1:0] acc_q,   acc_d;
  logic [W_CNT-1:0] cnt_q,   cnt_d;
  logic [3:0]       last_q,  last_d;
  logic             valid_q, valid_d;
  logic             sat_q,   sat_d;

  // ---------------------------------------------------------------------------
  // Arithmetic
  // ---------------------------------------------------------------------------
  // Both candidate results are formed one bit wider than the accumulator. For
  // the add, the extra MSB is the carry-out (result above ACC_MAX); for the
  // subtract it is the borrow (c > acc). Landing exactly on a limit leaves the
  // MSB clear, so that case is not reported as saturation.
  logic [W_ACC:0] c_ext;
  logic [W_ACC:0] sum_ext;
  logic [W_ACC:0] diff_ext;

  assign c_ext    = {{(W_ACC - 3){1'b0}}, c};
  assign sum_ext  = {1'b0, acc_q} + c_ext;
  assign diff_ext = {1'b0, acc_q} - c_ext;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default on the first lines of the
  // block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    valid_d = 1'b0;
    sat_d   = 1'b0;

    // b and c are only looked at under `a`, so X/Z on them while idle cannot
    // reach the state.
    if (a) begin
      cnt_d   = cnt_q + W_CNT'(1);
      last_d  = c;
      valid_d = 1'b1;

      if (!b) begin
        if (sum_ext[W_ACC]) begin
          acc_d = ACC_MAX;
          sat_d = 1'b1;
        end else begin
          acc_d = sum_ext[W_ACC-1:0];
        end
      end else begin
        if (diff_ext[W_ACC]) begin
          acc_d = '0;
          sat_d = 1'b1;
        end else begin
          acc_d = diff_ext[W_ACC-1:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_acc   = acc_q;
  assign o_cnt   = cnt_q;
  assign o_last  = last_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

  // o_hit follows the accumulator register combinationally, so it moves in
  // the same cycle as o_acc. It is gated by resetn so that it reads 0 during
  // reset even when THRESH is 0 (acc = 0 would otherwise satisfy the compare).
  assign o_hit = resetn && !THRESH_UNREACHABLE && ({1'b0, acc_q} >= THRESH_EXT);

endmodule

// File: tb/tb_some_sub_module.sv
// -----------------------------------------------------------------------------
// tb_some_sub_module
//
// Directed self-checking bench for some_sub_module with default parameters
// (W_ACC=8, W_CNT=8, THRESH=128). Inputs change on the falling edge; outputs
// are sampled 1 time unit after the rising edge. Every expected value below is
// worked out by hand from the accumulator's arithmetic.
// -----------------------------------------------------------------------------
module tb_some_sub_module;

  logic       i_clk;
  logic       resetn;
  logic       a;
  logic       b;
  logic [3:0] c;
  logic [7:0] o_acc;
  logic [7:0] o_cnt;
  logic [3:0] o_last;
  logic       o_valid;
  logic       o_sat;
  logic       o_hit;

  int total = 0;
  int bad   = 0;

  some_sub_module dut (
    .a       (a),
    .b       (b),
    .c       (c),
    .i_clk   (i_clk),
    .resetn  (resetn),
    .o_acc   (o_acc),
    .o_cnt   (o_cnt),
    .o_last  (o_last),
    .o_valid (o_valid),
    .o_sat   (o_sat),
    .o_hit   (o_hit)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag, input int e_acc, input int e_cnt,
                           input int e_last, input int e_valid, input int e_sat,
                           input int e_hit);
    check({tag, ".acc"},   32'(o_acc),   e_acc);
    check({tag, ".cnt"},   32'(o_cnt),   e_cnt);
    check({tag, ".last"},  32'(o_last),  e_last);
    check({tag, ".valid"}, 32'(o_valid), e_valid);
    check({tag, ".sat"},   32'(o_sat),   e_sat);
    check({tag, ".hit"},   32'(o_hit),   e_hit);
  endtask

  // One clock: apply inputs on the falling edge, sample just after the rise.
  task automatic step(input logic sa, input logic sb, input logic [3:0] sc);
    @(negedge i_clk);
    a = sa;
    b = sb;
    c = sc;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    a      = 1'b0;
    b      = 1'b0;
    c      = 4'd0;
    resetn = 1'b0;

    // 1. Reset held for 3 cycles, then released with a=0.
    repeat (3) step(1'b0, 1'b0, 4'd0);
    check_all("in_reset", 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    resetn = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    check_all("release", 0, 0, 0, 0, 0, 0);

    // 2. Three back-to-back adds of 5.
    step(1'b1, 1'b0, 4'd5);
    check_all("add5_1", 5, 1, 5, 1, 0, 0);
    step(1'b1, 1'b0, 4'd5);
    check_all("add5_2", 10, 2, 5, 1, 0, 0);
    step(1'b1, 1'b0, 4'd5);
    check_all("add5_3", 15, 3, 5, 1, 0, 0);
    step(1'b0, 1'b0, 4'd0);
    check_all("idle_1", 15, 3, 5, 0, 0, 0);

    // 3. Upper clamp. 15 + 15*15 + 10 = 250 after 16 more strobes (cnt 19).
    repeat (15) step(1'b1, 1'b0, 4'd15);
    step(1'b1, 1'b0, 4'd10);
    check_all("at250", 250, 19, 10, 1, 0, 1);
    step(1'b1, 1'b0, 4'd9);
    check_all("add9_clamp", 255, 20, 9, 1, 1, 1);
    step(1'b1, 1'b0, 4'd0);
    check_all("add0_at_max", 255, 21, 0, 1, 0, 1);
    step(1'b1, 1'b1, 4'd5);
    check_all("sub5_to_250", 250, 22, 5, 1, 0, 1);
    step(1'b1, 1'b0, 4'd5);
    check_all("add5_exact_max", 255, 23, 5, 1, 0, 1);

    // 4. Lower clamp. 255 - 16*15 = 15 (cnt 39), then -12 -> 3 (cnt 40).
    repeat (16) step(1'b1, 1'b1, 4'd15);
    check_all("at15", 15, 39, 15, 1, 0, 0);
    step(1'b1, 1'b1, 4'd12);
    check_all("at3", 3, 40, 12, 1, 0, 0);
    step(1'b1, 1'b1, 4'd7);
    check_all("sub7_clamp", 0, 41, 7, 1, 1, 0);
    step(1'b1, 1'b1, 4'd0);
    check_all("sub0_at_zero", 0, 42, 0, 1, 0, 0);
    step(1'b1, 1'b0, 4'd7);
    check_all("at7", 7, 43, 7, 1, 0, 0);
    step(1'b1, 1'b1, 4'd7);
    check_all("sub7_exact_zero", 0, 44, 7, 1, 0, 0);

    // 5. Threshold. 8*15 = 120 (cnt 52), +8 -> 128 hits, -1 -> 127 clears.
    repeat (8) step(1'b1, 1'b0, 4'd15);
    check_all("at120", 120, 52, 15, 1, 0, 0);
    step(1'b1, 1'b0, 4'd8);
    check_all("hit128", 128, 53, 8, 1, 0, 1);
    step(1'b1, 1'b1, 4'd1);
    check_all("miss127", 127, 54, 1, 1, 0, 0);

    // X on b and c while idle must not disturb anything.
    step(1'b0, 1'bx, 4'bxxxx);
    check_all("idle_x", 127, 54, 1, 0, 0, 0);

    // 6. Reach acc=77, cnt=255: 5 * (-10) -> 77 (cnt 59), then 196 zero adds.
    repeat (5) step(1'b1, 1'b1, 4'd10);
    check_all("at77", 77, 59, 10, 1, 0, 0);
    repeat (196) step(1'b1, 1'b0, 4'd0);
    check_all("cnt255", 77, 255, 0, 1, 0, 0);

    // Assert reset between edges with a strobe pending; outputs clear at once.
    #2;
    a      = 1'b1;
    b      = 1'b0;
    c      = 4'd5;
    resetn = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge i_clk);
    #1;
    check_all("reset_edge", 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    a      = 1'b0;
    resetn = 1'b1;
    step(1'b0, 1'b0, 4'd0);
    check_all("re_release", 0, 0, 0, 0, 0, 0);

    // 256 strobes of +1: acc climbs to 255 after 255 strobes, the 256th
    // clamps, and the counter wraps to 0.
    repeat (255) step(1'b1, 1'b0, 4'd1);
    check_all("cnt_255_again", 255, 255, 1, 1, 0, 1);
    step(1'b1, 1'b0, 4'd1);
    check_all("cnt_wrap", 255, 0, 1, 1, 1, 1);
    step(1'b0, 1'b0, 4'd0);
    check_all("final_idle", 255, 0, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
